// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: instruction
// field constants, ALU operation codes, datapath select encodings and the
// control FSM state type.
package mips_ctrl_pkg;

  // Instruction opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_OR  = 6'h25;

  // ALU operation codes
  localparam logic [3:0] ALU_LUI = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;

  // ALU B operand select
  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  // PC next-value select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_ALU_WB   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_TRAP     = 4'd12
  } state_t;

  // States that issue a memory request and may stall on mem_ready_i
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decoder.sv
// ALU operation decode: selects the ALU op code from the current control
// state and the instruction fields held in the IR. Purely combinational.
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_operation
);

  // States that do not use the ALU present code 0
  always_comb begin
    alu_operation = 4'b0000;
    case (state)
      ST_FETCH, ST_DECODE, ST_MEM_ADDR: alu_operation = ALU_ADD;
      ST_EXEC_R:  alu_operation = (funct == FUNCT_OR) ? ALU_OR : ALU_ADD;
      ST_EXEC_I: begin
        if (opcode == OP_ORI)      alu_operation = ALU_OR;
        else if (opcode == OP_LUI) alu_operation = ALU_LUI;
        else                       alu_operation = ALU_ADD;
      end
      ST_BRANCH:  alu_operation = ALU_SUB;
      default:    alu_operation = 4'b0000;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// writeback, drives the datapath selects and ALU op code, and stalls on
// the memory handshake.
//
// Memory handshake: a request (mem_read_o or mem_write_o) is held stable
// while the FSM sits in FETCH, MEM_RD or MEM_WR; the access completes in
// the cycle mem_ready_i is high, and the FSM leaves the state on that edge.
//
// Build option: define ILLEGAL_TRAP_EN to send unrecognised instructions to
// a terminal TRAP state; otherwise they behave as a NOP.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic [3:0]  alu_operation_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  pc_source_o,
  output logic        pc_en_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic        timeout_o,
  output logic [3:0]  state_o
);

  localparam logic [15:0] WAIT_LIMIT = 16'(MEM_WAIT_MAX);

  state_t      state, state_next;
  logic [15:0] wait_cnt;
  logic        timeout_q;
  logic        pc_write, pc_write_cond;
  logic        stalled;

  // Recognised instructions; anything else is illegal
  logic        legal_r;
  assign legal_r = (funct_i == FUNCT_ADD) || (funct_i == FUNCT_OR);
  assign stalled = is_mem_state(state) && !mem_ready_i;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   state_next = ST_FETCH;
      ST_FETCH:  if (mem_ready_i) state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode_i)
          OP_RTYPE: begin
            if (legal_r) state_next = ST_EXEC_R;
            else begin
`ifdef ILLEGAL_TRAP_EN
              state_next = ST_TRAP;
`else
              state_next = ST_FETCH;
`endif
            end
          end
          OP_ADDI, OP_ORI, OP_LUI: state_next = ST_EXEC_I;
          OP_LW, OP_SW:            state_next = ST_MEM_ADDR;
          OP_BEQ:                  state_next = ST_BRANCH;
          OP_J:                    state_next = ST_JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_next = ST_TRAP;
`else
            state_next = ST_FETCH;
`endif
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_next = ST_ALU_WB;
      ST_ALU_WB:   state_next = ST_FETCH;
      ST_MEM_ADDR: state_next = (opcode_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready_i) state_next = ST_MEM_WB;
      ST_MEM_WB:   state_next = ST_FETCH;
      ST_MEM_WR:   if (mem_ready_i) state_next = ST_FETCH;
      ST_BRANCH:   state_next = ST_FETCH;
      ST_JUMP:     state_next = ST_FETCH;
      ST_TRAP:     state_next = ST_TRAP;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Stall counter (zero whenever not stalled, so it starts at 0 on entry
  // to every memory state) and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (stalled) begin
      if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
      if ((WAIT_LIMIT != 16'd0) && (wait_cnt == WAIT_LIMIT - 16'd1))
        timeout_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Datapath control decode from state (FETCH completion and branch PC
  // enable also look at mem_ready_i / zero_i)
  always_comb begin
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = SRC_B_RT;
    pc_source_o   = PC_SRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d_o      = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    reg_write_o   = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write   = 1'b1;
        end
      end
      ST_DECODE:   alu_src_b_o = SRC_B_IMM_SH;
      ST_EXEC_R:   alu_src_a_o = 1'b1;
      ST_EXEC_I, ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
      end
      ST_ALU_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = (opcode_i == OP_RTYPE);
      end
      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_o   = 1'b1;
        pc_write_cond = 1'b1;
        pc_source_o   = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write    = 1'b1;
        pc_source_o = PC_SRC_JUMP;
      end
      default: ;
    endcase
    pc_en_o = pc_write | (pc_write_cond & zero_i);
  end

  alu_op_decoder u_alu_op_decoder (
    .state         (state),
    .opcode        (opcode_i),
    .funct         (funct_i),
    .alu_operation (alu_operation_o)
  );

  assign timeout_o = timeout_q;
  assign state_o   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-cycle expected output vectors are
// queued with their stimulus and compared as the FSM steps.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam logic [3:0] E_LUI = 4'b0000;
  localparam logic [3:0] E_OR  = 4'b0001;
  localparam logic [3:0] E_ADD = 4'b0011;
  localparam logic [3:0] E_SUB = 4'b0100;
  localparam int W = 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] opcode_i = '0, funct_i = '0;
  logic       zero_i = 1'b0, mem_ready_i = 1'b0;
  logic [3:0] alu_operation_o, state_o;
  logic       alu_src_a_o, pc_en_o, i_or_d_o, mem_read_o, mem_write_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic       ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, timeout_o;

  multicycle_control #(.MEM_WAIT_MAX(2)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .alu_operation_o(alu_operation_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .pc_source_o(pc_source_o), .pc_en_o(pc_en_o),
    .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .timeout_o(timeout_o), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  logic         z_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [W-1:0] ev(state_t st, logic [3:0] alu, logic sa,
      logic [1:0] sb, logic [1:0] ps, logic pe, logic iod, logic mr, logic mw,
      logic irw, logic rd, logic m2r, logic rw, logic to);
    return {st, alu, sa, sb, ps, pe, iod, mr, mw, irw, rd, m2r, rw, to};
  endfunction

  function automatic logic [W-1:0] obs();
    return {state_o, alu_operation_o, alu_src_a_o, alu_src_b_o, pc_source_o,
            pc_en_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
            reg_dst_o, mem_to_reg_o, reg_write_o, timeout_o};
  endfunction

  // Expected per-state output vectors
  function automatic logic [W-1:0] v_idle(logic to);
    return ev(ST_IDLE, 4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, to);
  endfunction
  function automatic logic [W-1:0] v_fetch(logic rdy, logic to);
    return ev(ST_FETCH, E_ADD, 0, 2'd1, 2'd0, rdy, 0, 1, 0, rdy, 0, 0, 0, to);
  endfunction
  function automatic logic [W-1:0] v_decode(logic to);
    return ev(ST_DECODE, E_ADD, 0, 2'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, to);
  endfunction
  function automatic logic [W-1:0] v_exec_r(logic [3:0] op);
    return ev(ST_EXEC_R, op, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] v_exec_i(logic [3:0] op);
    return ev(ST_EXEC_I, op, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] v_alu_wb(logic rd);
    return ev(ST_ALU_WB, 4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, rd, 0, 1, 0);
  endfunction
  function automatic logic [W-1:0] v_mem_addr();
    return ev(ST_MEM_ADDR, E_ADD, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] v_mem_rd(logic to);
    return ev(ST_MEM_RD, 4'd0, 0, 2'd0, 2'd0, 0, 1, 1, 0, 0, 0, 0, 0, to);
  endfunction
  function automatic logic [W-1:0] v_mem_wb(logic to);
    return ev(ST_MEM_WB, 4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1, to);
  endfunction
  function automatic logic [W-1:0] v_mem_wr(logic to);
    return ev(ST_MEM_WR, 4'd0, 0, 2'd0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, to);
  endfunction
  function automatic logic [W-1:0] v_branch(logic z);
    return ev(ST_BRANCH, E_SUB, 1, 2'd0, 2'd1, z, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] v_jump();
    return ev(ST_JUMP, 4'd0, 0, 2'd0, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] v_trap();
    return ev(ST_TRAP, 4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // ---------------- driver tasks ----------------
  // Queue one cycle: expected outputs plus the inputs to apply that cycle
  task automatic sched(input logic [W-1:0] v, input logic rdy, input logic z);
    exp_q.push_back(v);
    rdy_q.push_back(rdy);
    z_q.push_back(z);
  endtask

  // Apply inputs at the falling edge, then let combinational outputs settle
  task automatic drive(input logic rdy, input logic z);
    mem_ready_i = rdy;
    zero_i      = z;
    #1;
  endtask

  task automatic advance();
    @(negedge clk);
  endtask

  // Leaves reset released at a falling edge; FSM is in IDLE for this cycle
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready_i = 1'b0;
    zero_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] got, exp;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (obs() !== v_idle(0)) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=%h", obs(), v_idle(0));
    end
    @(negedge clk);
    reset = 1'b0;
    sched(v_idle(0), 0, 0);
    sched(v_fetch(0, 0), 0, 0);
    while (exp_q.size() > 0) begin
      drive(rdy_q.pop_front(), z_q.pop_front());
      got = obs(); exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_release got=%h exp=%h", got, exp);
      end
      advance();
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [3:0] op);
    logic [W-1:0] got, exp;
    apply_reset();
    opcode_i = OP_RTYPE; funct_i = fn;
    sched(v_idle(0), 1, 0);
    sched(v_fetch(1, 0), 1, 0);
    sched(v_decode(0), 1, 0);
    sched(v_exec_r(op), 1, 0);
    sched(v_alu_wb(1), 1, 0);
    sched(v_fetch(1, 0), 1, 0);
    while (exp_q.size() > 0) begin
      drive(rdy_q.pop_front(), z_q.pop_front());
      got = obs(); exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rtype funct=%h got=%h exp=%h", fn, got, exp);
      end
      advance();
    end
  endtask

  task automatic test_itype(input logic [5:0] opc, input logic [3:0] op);
    logic [W-1:0] got, exp;
    apply_reset();
    opcode_i = opc; funct_i = 6'($urandom_range(0, 63));
    sched(v_idle(0), 1, 0);
    sched(v_fetch(1, 0), 1, 0);
    sched(v_decode(0), 1, 0);
    sched(v_exec_i(op), 1, 0);
    sched(v_alu_wb(0), 1, 0);
    sched(v_fetch(1, 0), 1, 0);
    while (exp_q.size() > 0) begin
      drive(rdy_q.pop_front(), z_q.pop_front());
      got = obs(); exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL itype op=%h got=%h exp=%h", opc, got, exp);
      end
      advance();
    end
  endtask

  // lw with three stalled cycles in MEM_RD; limit 2 raises timeout
  task automatic test_lw_stall();
    logic [W-1:0] got, exp;
    apply_reset();
    opcode_i = OP_LW; funct_i = 6'h00;
    sched(v_idle(0), 1, 0);
    sched(v_fetch(1, 0), 1, 0);
    sched(v_decode(0), 1, 0);
    sched(v_mem_addr(), 1, 0);
    sched(v_mem_rd(0), 0, 0);
    sched(v_mem_rd(0), 0, 0);
    sched(v_mem_rd(1), 0, 0);
    sched(v_mem_rd(1), 1, 0);
    sched(v_mem_wb(1), 1, 0);
    sched(v_fetch(1, 1), 1, 0);
    while (exp_q.size() > 0) begin
      drive(rdy_q.pop_front(), z_q.pop_front());
      got = obs(); exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL lw_stall got=%h exp=%h", got, exp);
      end
      advance();
    end
  endtask

  task automatic test_sw();
    logic [W-1:0] got, exp;
    apply_reset();
    opcode_i = OP_SW; funct_i = 6'h00;
    sched(v_idle(0), 1, 0);
    sched(v_fetch(1, 0), 1, 0);
    sched(v_decode(0), 1, 0);
    sched(v_mem_addr(), 1, 0);
    sched(v_mem_wr(0), 1, 0);
    sched(v_fetch(1, 0), 1, 0);
    while (exp_q.size() > 0) begin
      drive(rdy_q.pop_front(), z_q.pop_front());
      got = obs(); exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sw got=%h exp=%h", got, exp);
      end
      advance();
    end
  endtask

  task automatic test_branch(input logic z);
    logic [W-1:0] got, exp;
    apply_reset();
    opcode_i = OP_BEQ; funct_i = 6'h00;
    sched(v_idle(0), 1, !z);
    sched(v_fetch(1, 0), 1, !z);
    sched(v_decode(0), 1, !z);
    sched(v_branch(z), 1, z);
    sched(v_fetch(1, 0), 1, !z);
    while (exp_q.size() > 0) begin
      drive(rdy_q.pop_front(), z_q.pop_front());
      got = obs(); exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL beq zero=%0b got=%h exp=%h", z, got, exp);
      end
      advance();
    end
  endtask

  // Jump, with a one-cycle fetch stall first
  task automatic test_jump();
    logic [W-1:0] got, exp;
    apply_reset();
    opcode_i = OP_J; funct_i = 6'h00;
    sched(v_idle(0), 0, 0);
    sched(v_fetch(0, 0), 0, 0);
    sched(v_fetch(1, 0), 1, 0);
    sched(v_decode(0), 1, 0);
    sched(v_jump(), 1, 0);
    sched(v_fetch(1, 0), 1, 0);
    while (exp_q.size() > 0) begin
      drive(rdy_q.pop_front(), z_q.pop_front());
      got = obs(); exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL jump got=%h exp=%h", got, exp);
      end
      advance();
    end
  endtask

  task automatic test_illegal(input logic [5:0] opc, input logic [5:0] fn);
    logic [W-1:0] got, exp;
    apply_reset();
    opcode_i = opc; funct_i = fn;
    sched(v_idle(0), 1, 0);
    sched(v_fetch(1, 0), 1, 0);
    sched(v_decode(0), 1, 1);
`ifdef ILLEGAL_TRAP_EN
    sched(v_trap(), 1, 1);
    sched(v_trap(), 1, 1);
    sched(v_trap(), 0, 1);
`else
    sched(v_fetch(0, 0), 0, 1);
`endif
    while (exp_q.size() > 0) begin
      drive(rdy_q.pop_front(), z_q.pop_front());
      got = obs(); exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL illegal op=%h fn=%h got=%h exp=%h", opc, fn, got, exp);
      end
      advance();
    end
  endtask

  // Reset while a write is stalled past the timeout limit
  task automatic test_reset_mid_write();
    logic [W-1:0] got, exp;
    apply_reset();
    opcode_i = OP_SW; funct_i = 6'h00;
    sched(v_idle(0), 1, 0);
    sched(v_fetch(1, 0), 1, 0);
    sched(v_decode(0), 1, 0);
    sched(v_mem_addr(), 0, 0);
    sched(v_mem_wr(0), 0, 0);
    sched(v_mem_wr(0), 0, 0);
    sched(v_mem_wr(1), 0, 0);
    sched(v_mem_wr(1), 0, 0);
    while (exp_q.size() > 0) begin
      drive(rdy_q.pop_front(), z_q.pop_front());
      got = obs(); exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL write_stall got=%h exp=%h", got, exp);
      end
      advance();
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({mem_write_o, timeout_o, state_o} !== {1'b0, 1'b0, ST_IDLE}) begin
      n_fail++;
      $display("FAIL async_reset wr=%0b to=%0b st=%0d exp=0 0 %0d",
               mem_write_o, timeout_o, state_o, ST_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    sched(v_idle(0), 0, 0);
    sched(v_fetch(0, 0), 0, 0);
    while (exp_q.size() > 0) begin
      drive(rdy_q.pop_front(), z_q.pop_front());
      got = obs(); exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL post_reset got=%h exp=%h", got, exp);
      end
      advance();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rtype(FUNCT_ADD, E_ADD);
    test_rtype(FUNCT_OR, E_OR);
    test_itype(OP_LUI, E_LUI);
    test_itype(OP_ORI, E_OR);
    test_itype(OP_ADDI, E_ADD);
    test_lw_stall();
    test_sw();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump();
    test_illegal(6'h3F, 6'h00);
    test_illegal(OP_RTYPE, 6'h22);
    test_reset_mid_write();
    test_rtype(FUNCT_ADD, E_ADD);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
